// File: rtl/sp_ram_req_adapter.sv
// Valid/ready front end for a single-port RAM with fixed one-cycle read latency.
// Out-of-range requests bypass the RAM and return an error response in order.
module sp_ram_req_adapter #(
  parameter int unsigned RAM_SIZE       = 32768,
  parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REQ_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [REQ_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_we_i,
  input  logic [DATA_WIDTH/8-1:0]   req_be_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

  localparam logic [REQ_ADDR_WIDTH-1:0] LP_RAM_SIZE = REQ_ADDR_WIDTH'(RAM_SIZE);

  logic                  w_req_fire;
  logic                  w_in_range;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_outstanding;
  logic [DATA_WIDTH-1:0] w_pend_data;

  logic                  r_pend;
  logic                  r_pend_we;
  logic                  r_pend_err;
  logic [1:0]            r_count;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_fifo_err  [2];

  // Credit counts both buffered and in-flight responses, from registers only.
  assign w_outstanding = {1'b0, r_count} + {2'b00, r_pend};
  assign req_ready_o   = (w_outstanding < 3'd2);

  assign w_req_fire = req_valid_i & req_ready_o;
  assign w_in_range = (req_addr_i < LP_RAM_SIZE);

  // Reset gating keeps the RAM idle even though ready is high during reset.
  assign ram_en_o    = w_req_fire & w_in_range & rstn_i;
  assign ram_addr_o  = req_addr_i[ADDR_WIDTH-1:0];
  assign ram_wdata_o = req_wdata_i;
  assign ram_we_o    = req_we_i;
  assign ram_be_o    = req_be_i;

  assign w_pend_data = (r_pend_err | r_pend_we) ? '0 : ram_rdata_i;

  assign w_pop  = (r_count != 2'd0) & rsp_ready_i;
  assign w_push = r_pend & ~((r_count == 2'd0) & rsp_ready_i);

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend     <= 1'b0;
      r_pend_we  <= 1'b0;
      r_pend_err <= 1'b0;
    end else begin
      r_pend     <= w_req_fire;
      r_pend_we  <= w_req_fire & req_we_i;
      r_pend_err <= w_req_fire & ~w_in_range;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count        <= 2'd0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_err[0]  <= 1'b0;
      r_fifo_err[1]  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_pend_data;
        r_fifo_err[r_wptr]  <= r_pend_err;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffered entries are older than the pending one, so they go first.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    if (r_count != 2'd0) begin
      rsp_valid_o = 1'b1;
      rsp_rdata_o = r_fifo_data[r_rptr];
      rsp_err_o   = r_fifo_err[r_rptr];
    end else if (r_pend) begin
      rsp_valid_o = 1'b1;
      rsp_rdata_o = w_pend_data;
      rsp_err_o   = r_pend_err;
    end
  end

endmodule

// File: tb/tb_sp_ram_req_adapter.sv
// Scoreboard bench for sp_ram_req_adapter: request-level memory model predicts
// every response; a behavioural one-cycle RAM stands in for the real array.
module tb_sp_ram_req_adapter;

  localparam int unsigned RamSize = 32768;
  localparam int unsigned Aw      = 15;
  localparam int unsigned Dw      = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          req_we_i;
  logic [3:0]    req_be_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          ram_en_o;
  logic [Aw-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_rdata_i;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;
  rsp_t sb[$];

  logic [31:0] model_mem [0:8191];
  logic [31:0] ram_mem   [0:8191];

  always #5 clk = ~clk;

  sp_ram_req_adapter #(
    .RAM_SIZE       (RamSize),
    .ADDR_WIDTH     (Aw),
    .DATA_WIDTH     (Dw),
    .REQ_ADDR_WIDTH (32)
  ) u_dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_rdata_i (ram_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM stand-in: strobes sampled mid-cycle, applied at the edge. Write cycles
  // return junk so the DUT's zeroing of write responses is exercised.
  initial begin
    logic          en_s;
    logic          we_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s;
    logic [Aw-1:0] ad_s;
    for (int i = 0; i < 8192; i++) ram_mem[i] = 32'h0;
    ram_rdata_i = 32'h5A5A5A5A;
    forever begin
      @(negedge clk);
      en_s = ram_en_o;
      we_s = ram_we_o;
      be_s = ram_be_o;
      wd_s = ram_wdata_o;
      ad_s = ram_addr_o;
      @(posedge clk);
      if (en_s) begin
        if (we_s) begin
          for (int b = 0; b < 4; b++)
            if (be_s[b]) ram_mem[ad_s[14:2]][8*b +: 8] = wd_s[8*b +: 8];
          ram_rdata_i <= 32'hBAD0BAD0;
        end else begin
          ram_rdata_i <= ram_mem[ad_s[14:2]];
        end
      end
    end
  end

  // Monitor: compare consumed responses against the queue, then log new accepts.
  initial begin
    rsp_t        e;
    logic        exp_en;
    logic [12:0] widx;
    for (int i = 0; i < 8192; i++) model_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (rstn_i) begin
        exp_en = req_valid_i && req_ready_o && (req_addr_i < RamSize);
        check_eq("ram_en", 64'(ram_en_o), 64'(exp_en));
        if (rsp_valid_o && rsp_ready_i) begin
          n_rsp++;
          check_eq("rsp_expected", 64'(sb.size() != 0), 64'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
            check_eq("rsp_err", 64'(rsp_err_o), 64'(e.err));
          end
        end
        if (req_valid_i && req_ready_o) begin
          widx = req_addr_i[14:2];
          if (req_addr_i >= RamSize) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
          end else if (req_we_i) begin
            for (int b = 0; b < 4; b++)
              if (req_be_i[b]) model_mem[widx][8*b +: 8] = req_wdata_i[8*b +: 8];
            e.rdata = 32'h0;
            e.err   = 1'b0;
          end else begin
            e.rdata = model_mem[widx];
            e.err   = 1'b0;
          end
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_we_i    = we;
    req_be_i    = be;
    req_wdata_i = wd;
  endtask

  task automatic wait_accept(output int waits);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!req_ready_o && waits < 50);
    check_eq("accept", 64'(req_ready_o), 64'(1));
    tick();
  endtask

  task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output int waits);
    drive(a, we, be, wd);
    wait_accept(waits);
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int w;
    int stalls;
    int gaps;
    int n0;

    rstn_i      = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h10;
    req_we_i    = 1'b0;
    req_be_i    = 4'h0;
    req_wdata_i = 32'h0;
    rsp_ready_i = 1'b0;
    #2;
    check_eq("rst_ram_en", 64'(ram_en_o), 64'(0));
    check_eq("rst_req_ready", 64'(req_ready_o), 64'(1));
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check_eq("rst_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err_o), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    idle();
    rstn_i      = 1'b1;
    rsp_ready_i = 1'b1;
    tick();

    // Write then read back with one-cycle latency.
    send(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, w);
    check_eq("wr_lat_valid", 64'(rsp_valid_o), 64'(1));
    check_eq("wr_lat_rdata", 64'(rsp_rdata_o), 64'(0));
    send(32'h10, 1'b0, 4'h0, 32'h0, w);
    check_eq("rd_lat_valid", 64'(rsp_valid_o), 64'(1));
    check_eq("rd_lat_rdata", 64'(rsp_rdata_o), 64'hDEADBEEF);
    idle();
    drain();

    // Byte-enable merge.
    send(32'h20, 1'b1, 4'hF, 32'h11223344, w);
    send(32'h20, 1'b1, 4'b0010, 32'h0000AA00, w);
    send(32'h20, 1'b0, 4'h0, 32'h0, w);
    check_eq("merge_rdata", 64'(rsp_rdata_o), 64'h1122AA44);
    idle();
    drain();

    // Out-of-range read sandwiched between in-range reads.
    send(32'h10, 1'b0, 4'h0, 32'h0, w);
    send(32'h8000, 1'b0, 4'h0, 32'h0, w);
    check_eq("oor_err", 64'(rsp_err_o), 64'(1));
    check_eq("oor_rdata", 64'(rsp_rdata_o), 64'(0));
    send(32'h20, 1'b0, 4'h0, 32'h0, w);
    check_eq("oor_next_rdata", 64'(rsp_rdata_o), 64'h1122AA44);
    idle();
    drain();

    // Backpressure: two outstanding max, then drain in order.
    send(32'h0, 1'b1, 4'hF, 32'hA0A0A0A0, w);
    send(32'h4, 1'b1, 4'hF, 32'hA4A4A4A4, w);
    send(32'h8, 1'b1, 4'hF, 32'hA8A8A8A8, w);
    idle();
    drain();
    rsp_ready_i = 1'b0;
    send(32'h0, 1'b0, 4'h0, 32'h0, w);
    check_eq("bp_ready_after1", 64'(req_ready_o), 64'(1));
    send(32'h4, 1'b0, 4'h0, 32'h0, w);
    check_eq("bp_ready_after2", 64'(req_ready_o), 64'(0));
    drive(32'h8, 1'b0, 4'h0, 32'h0);
    repeat (3) tick();
    check_eq("bp_stall", 64'(req_ready_o), 64'(0));
    check_eq("bp_head_valid", 64'(rsp_valid_o), 64'(1));
    check_eq("bp_head_rdata", 64'(rsp_rdata_o), 64'hA0A0A0A0);
    rsp_ready_i = 1'b1;
    wait_accept(w);
    idle();
    drain();

    // Sustained streaming.
    stalls = 0;
    gaps   = 0;
    n0     = n_rsp;
    for (int i = 0; i < 16; i++) begin
      send(32'(i * 4), 1'b0, 4'h0, 32'h0, w);
      if (w > 1) stalls++;
      if (!rsp_valid_o) gaps++;
    end
    idle();
    drain();
    check_eq("stream_stalls", 64'(stalls), 64'(0));
    check_eq("stream_gaps", 64'(gaps), 64'(0));
    check_eq("stream_count", 64'(n_rsp - n0), 64'(16));

    // Reset with two responses buffered.
    rsp_ready_i = 1'b0;
    send(32'h0, 1'b0, 4'h0, 32'h0, w);
    send(32'h4, 1'b0, 4'h0, 32'h0, w);
    idle();
    tick();
    check_eq("rst_pre_valid", 64'(rsp_valid_o), 64'(1));
    rstn_i = 1'b0;
    #1;
    check_eq("rst_mid_valid", 64'(rsp_valid_o), 64'(0));
    check_eq("rst_mid_ready", 64'(req_ready_o), 64'(1));
    sb.delete();
    repeat (2) tick();
    rstn_i      = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst_stale", 64'(rsp_valid_o), 64'(0));
    end
    check_eq("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_ram_req_adapter.md
# sp_ram_req_adapter

Valid/ready front end for the single-port data/instruction RAM wrapper. Converts a pipelined request stream into RAM enable, address, write and byte-enable strobes, and tracks the RAM's fixed one-cycle read latency. Returns every request's result through a valid/ready response channel with a 2-entry skid FIFO. Out-of-range addresses are answered with an error response and never reach the RAM.

## Interface
Parameters:
- RAM_SIZE, 32768: RAM size in bytes.
- ADDR_WIDTH, $clog2(RAM_SIZE): RAM-side byte-address width.
- DATA_WIDTH, 32: data width; byte enables are DATA_WIDTH/8 bits.
- REQ_ADDR_WIDTH, 32: request-side byte-address width, ≥ ADDR_WIDTH.

Ports:
- clk  in  1  the single clock.
- rstn_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- req_addr_i  in  REQ_ADDR_WIDTH  byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_be_i  in  DATA_WIDTH/8  byte enables, used for writes only.
- req_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  address out of range.
- ram_en_o  out  1  RAM enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, req_addr_i[ADDR_WIDTH-1:0].
- ram_wdata_o  out  DATA_WIDTH  passes req_wdata_i.
- ram_we_o  out  1  passes req_we_i.
- ram_be_o  out  DATA_WIDTH/8  passes req_be_i.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en_o.

## Operation
- Handshake: req_fire = req_valid_i & req_ready_o.
- Range check: in_range = (req_addr_i < RAM_SIZE), compared at full REQ_ADDR_WIDTH.
- RAM strobe: ram_en_o = req_fire & in_range, combinational in the same cycle.
  - ram_addr/wdata/we/be always pass the request fields through; the RAM ignores them while en is low.
- Pending stage (registers pend_q, pend_we_q, pend_err_q): loaded with {1, req_we_i, ~in_range} on req_fire, otherwise cleared. This is exactly one cycle of latency.
- Pending result data:
  - pend_err_q or pend_we_q: DATA_WIDTH'0.
  - otherwise: ram_rdata_i.
- Response FIFO: 2 entries of {rdata, err}, with count_q in 0..2 and read/write pointers that wrap modulo 2.
- Response mux:
  - count_q > 0: present the FIFO head.
  - count_q == 0 and pend_q: present the pending result directly (bypass, no added latency).
  - otherwise: rsp_valid_o = 0.
- FIFO push: pend_q & ~(count_q == 0 & rsp_ready_i), i.e. the pending result was not consumed through the bypass.
- FIFO pop: count_q > 0 & rsp_ready_i.
- Push and pop in the same cycle: count_q is unchanged, and entry order is preserved.
- Credit: req_ready_o = (count_q + pend_q) < 2, computed from registers only. There is no combinational path from rsp_ready_i or req_valid_i to req_ready_o.
- Ordering: responses leave strictly in request order, including error responses and write acknowledges.

## Timing
- Reset (rstn_i low, asynchronous): pend_q = 0, count_q = 0, pointers = 0.
  - Resulting outputs: req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - ram_en_o = 0 while rstn_i is low, independent of req_valid_i.
- Reset mid-operation discards in-flight and buffered responses. No response is issued after reset release.
- Latency: request accepted in cycle N gives rsp_valid_o in cycle N+1 when the FIFO is empty. Otherwise the response follows the older buffered entries.
- Throughput: one request per cycle sustained while rsp_ready_i = 1.
- Backpressure sequence when rsp_ready_i = 0:
  - After the first accept, req_ready_o stays 1.
  - After the second accept, count + pend reaches 2 and req_ready_o = 0.
  - A maximum of 2 responses are ever outstanding.
- When rsp_ready_i rises with count_q = 2: the pop frees a credit, and req_ready_o returns to 1 on the following cycle.
- rsp_valid_o, once asserted, holds with stable rdata/err until it is consumed.

## Test plan
- Write 0xDEADBEEF, be 4'b1111, to addr 0x10; then read 0x10 with rsp_ready_i = 1 → write response (rdata 0, err 0) in cycle N+1; read response 0xDEADBEEF one cycle after the read is accepted.
- Write 0x11223344 to 0x20, then write be 4'b0010 data 0x0000AA00 to 0x20, then read 0x20 → read response 0x1122AA44.
- Read addr 0x8000 with RAM_SIZE 32768 → ram_en_o stays 0; response err = 1, rdata = 0; neighbouring in-range responses are unaffected and stay in order.
- Three back-to-back reads of 0x0/0x4/0x8 with rsp_ready_i = 0 → req_ready_o falls after the second accept and the third stalls; raising rsp_ready_i drains the responses in order 0x0, 0x4, 0x8 with no loss or duplication.
- Stream 16 consecutive reads with rsp_ready_i = 1 → 16 responses on 16 consecutive cycles; req_ready_o never deasserts.
- Assert rstn_i low with 2 responses buffered → rsp_valid_o = 0 and req_ready_o = 1 immediately; after release, no stale response appears.
